// File: rtl/muldiv_unit_pkg.sv
// Shared opcode values, FSM encoding and opcode classification helpers for the
// RV32M multiply/divide engine, so ALU_Control, ALU and this block stay in step.
package muldiv_unit_pkg;

  localparam int ALU_CTRL_W = 6;

  localparam logic [ALU_CTRL_W-1:0] ALU_MUL    = 6'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULH   = 6'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULHU  = 6'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULHSU = 6'd9;
  localparam logic [ALU_CTRL_W-1:0] ALU_DIV    = 6'd10;
  localparam logic [ALU_CTRL_W-1:0] ALU_DIVU   = 6'd11;
  localparam logic [ALU_CTRL_W-1:0] ALU_REM    = 6'd12;
  localparam logic [ALU_CTRL_W-1:0] ALU_REMU   = 6'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input logic [ALU_CTRL_W-1:0] code);
    return (code >= ALU_MUL) && (code <= ALU_REMU);
  endfunction

  function automatic logic is_div_class(input logic [ALU_CTRL_W-1:0] code);
    return (code >= ALU_DIV) && (code <= ALU_REMU);
  endfunction

  // Operands treated as two's complement: rs1 for mulh/mulhsu/div/rem.
  function automatic logic signed_a(input logic [ALU_CTRL_W-1:0] code);
    return (code == ALU_MULH) || (code == ALU_MULHSU) ||
           (code == ALU_DIV)  || (code == ALU_REM);
  endfunction

  function automatic logic signed_b(input logic [ALU_CTRL_W-1:0] code);
    return (code == ALU_MULH) || (code == ALU_DIV) || (code == ALU_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide engine.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic                                   start;
  logic [muldiv_unit_pkg::ALU_CTRL_W-1:0] alu_ctrl;
  logic [XLEN-1:0]                        op_a;
  logic [XLEN-1:0]                        op_b;
  logic                                   flush;
  logic                                   busy;
  logic                                   done;
  logic [XLEN-1:0]                        result;

  modport master (
    output start, alu_ctrl, op_a, op_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, alu_ctrl, op_a, op_b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation, shared by operand magnitude,
// product and quotient/remainder sign fix-up.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_y
);
  assign o_y = i_neg ? (~i_x + W'(1)) : i_x;
endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative RV32M multiply/divide engine: one shift-add or restoring
// divide step per cycle, with a single-cycle fast path for div/rem corner cases.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           rst_n,
  muldiv_unit_if.slave  bus
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t              r_state;
  md_state_t              w_state_next;
  logic [ALU_CTRL_W-1:0]  r_op;
  logic                   r_sign_a;
  logic                   r_sign_b;
  logic [CNT_W-1:0]       r_cnt;
  logic [XLEN-1:0]        r_mag;
  logic [2*XLEN-1:0]      r_acc;
  logic [XLEN-1:0]        r_rem;
  logic [XLEN-1:0]        r_quot;
  logic [XLEN-1:0]        r_result;

  logic                   w_accept;
  logic                   w_fast;
  logic                   w_last;
  logic                   w_busy;
  logic                   w_done;
  logic                   w_load_result;
  logic                   w_in_sign_a;
  logic                   w_in_sign_b;
  logic [XLEN-1:0]        w_mag_a;
  logic [XLEN-1:0]        w_mag_b;
  logic [XLEN-1:0]        w_fast_result;
  logic [XLEN-1:0]        w_final_result;
  logic [XLEN-1:0]        w_result_next;

  logic [XLEN:0]          w_mul_sum;
  logic [2*XLEN-1:0]      w_acc_next;
  logic [XLEN:0]          w_trial;
  logic [XLEN-1:0]        w_sub;
  logic                   w_fits;
  logic [XLEN-1:0]        w_rem_next;
  logic [XLEN-1:0]        w_quot_next;
  logic [2*XLEN-1:0]      w_prod;
  logic [XLEN-1:0]        w_quot_fix;
  logic [XLEN-1:0]        w_rem_fix;

  assign w_in_sign_a = signed_a(bus.alu_ctrl) & bus.op_a[XLEN-1];
  assign w_in_sign_b = signed_b(bus.alu_ctrl) & bus.op_b[XLEN-1];

  muldiv_negate #(.W(XLEN)) u_mag_a (
    .i_neg (w_in_sign_a),
    .i_x   (bus.op_a),
    .o_y   (w_mag_a)
  );

  muldiv_negate #(.W(XLEN)) u_mag_b (
    .i_neg (w_in_sign_b),
    .i_x   (bus.op_b),
    .o_y   (w_mag_b)
  );

  assign w_accept = (r_state == ST_IDLE) & bus.start & is_muldiv(bus.alu_ctrl) & ~bus.flush;

  // Division by zero and signed overflow are resolved without iterating.
  assign w_fast = is_div_class(bus.alu_ctrl) &
                  ((bus.op_b == '0) |
                   (((bus.alu_ctrl == ALU_DIV) | (bus.alu_ctrl == ALU_REM)) &
                    (bus.op_a == INT_MIN) & (bus.op_b == '1)));

  always_comb begin
    w_fast_result = '0;
    if ((bus.alu_ctrl == ALU_DIV) || (bus.alu_ctrl == ALU_DIVU))
      w_fast_result = (bus.op_b == '0) ? '1 : bus.op_a;
    else
      w_fast_result = (bus.op_b == '0) ? bus.op_a : '0;
  end

  // Multiply step: multiplier sits in the low half of the accumulator and is
  // consumed LSB first while partial sums shift in from the top.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag} : '0);
  assign w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring divide step: dividend bits shift out of r_quot MSB first and
  // quotient bits shift in at the bottom.
  assign w_trial     = {r_rem, r_quot[XLEN-1]};
  assign w_fits      = (w_trial >= {1'b0, r_mag});
  assign w_sub       = w_trial[XLEN-1:0] - r_mag;
  assign w_rem_next  = w_fits ? w_sub : w_trial[XLEN-1:0];
  assign w_quot_next = {r_quot[XLEN-2:0], w_fits};

  muldiv_negate #(.W(2*XLEN)) u_fix_prod (
    .i_neg (r_sign_a ^ r_sign_b),
    .i_x   (w_acc_next),
    .o_y   (w_prod)
  );

  muldiv_negate #(.W(XLEN)) u_fix_quot (
    .i_neg (r_sign_a ^ r_sign_b),
    .i_x   (w_quot_next),
    .o_y   (w_quot_fix)
  );

  muldiv_negate #(.W(XLEN)) u_fix_rem (
    .i_neg (r_sign_a),
    .i_x   (w_rem_next),
    .o_y   (w_rem_fix)
  );

  always_comb begin
    w_final_result = '0;
    case (r_op)
      ALU_MUL:                          w_final_result = w_prod[XLEN-1:0];
      ALU_MULH, ALU_MULHU, ALU_MULHSU:  w_final_result = w_prod[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:                w_final_result = w_quot_fix;
      ALU_REM, ALU_REMU:                w_final_result = w_rem_fix;
      default:                          w_final_result = '0;
    endcase
  end

  assign w_last        = (r_cnt == CNT_W'(XLEN - 1));
  assign w_result_next = (r_state == ST_IDLE) ? w_fast_result : w_final_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    w_load_result = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next  = w_fast ? ST_DONE : ST_CALC;
          w_load_result = w_fast;
        end
      end
      ST_CALC: begin
        w_busy = 1'b1;
        if (bus.flush) begin
          w_state_next = ST_IDLE;
        end else if (w_last) begin
          w_state_next  = ST_DONE;
          w_load_result = 1'b1;
        end
      end
      ST_DONE: begin
        w_busy       = 1'b1;
        w_done       = ~bus.flush;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_cnt    <= '0;
      r_mag    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= bus.alu_ctrl;
        r_sign_a <= w_in_sign_a;
        r_sign_b <= w_in_sign_b;
        r_cnt    <= '0;
        r_mag    <= is_div_class(bus.alu_ctrl) ? w_mag_b : w_mag_a;
        r_acc    <= {{XLEN{1'b0}}, w_mag_b};
        r_rem    <= '0;
        r_quot   <= w_mag_a;
      end else if (r_state == ST_CALC) begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_acc  <= w_acc_next;
        r_rem  <= w_rem_next;
        r_quot <= w_quot_next;
      end
      if (w_load_result)
        r_result <= w_result_next;
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;

endmodule
